// File: rtl/ssram_to_ahb_if.sv
// ssram_to_ahb_if: AHB-Lite master/slave signal bundle for the SSRAM bridge
interface ssram_to_ahb_if;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;
   modport master (output HADDR, HTRANS, HSIZE, HWRITE, HBURST, HPROT, HWDATA, input HRDATA, HREADY, HRESP);
   modport slave  (input HADDR, HTRANS, HSIZE, HWRITE, HBURST, HPROT, HWDATA, output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/ssram_to_ahb.sv
// ssram_to_ahb: SSRAM request port to AHB-Lite master; SSRAM_TO_AHB_ERR_EN makes ERROR abort and pulse err
module ssram_to_ahb #(
   parameter int          AW        = 12,
   parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
   input  logic          HCLK,
   input  logic          rst,
   input  logic          sram_ahb_en,
   input  logic          sram_ahb_we,
   input  logic [3:0]    sram_ahb_wb,
   input  logic [AW-1:0] sram_ahb_addr,
   input  logic [31:0]   sram_ahb_din,
   output logic          ahb_sram_ready,
   output logic          ahb_sram_done,
   output logic [31:0]   ahb_sram_dout,
   output logic          ahb_sram_err,
   ssram_to_ahb_if.master ahb
);
   localparam logic [1:0]  S_IDLE = 2'd0;
   localparam logic [1:0]  S_ADDR = 2'd1;
   localparam logic [1:0]  S_DATA = 2'd2;
   localparam logic [31:0] HI     = 32'hffff_ffff << AW;
`ifdef SSRAM_TO_AHB_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif
   function automatic logic [1:0] lo_idx(input logic [3:0] m);
      return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
   endfunction
   function automatic logic [2:0] sz_of(input logic [3:0] m);
      return (m == 4'hf) ? 3'b010 : (m == 4'h3 || m == 4'hc) ? 3'b001 : 3'b000;
   endfunction
   logic [1:0]  state;
   logic [3:0]  mask;
   logic [31:0] din_r;
   logic [3:0]  m0;
   logic [31:0] addr_ext;
   logic [3:0]  nxt_mask;
   logic        abort;
   logic        last;
   assign m0       = sram_ahb_we ? sram_ahb_wb : 4'hf;
   assign addr_ext = 32'(sram_ahb_addr);
   assign abort    = ERR_EN & ahb.HRESP;
   assign ahb_sram_ready = (state == S_IDLE);
   assign ahb.HTRANS = (state == S_ADDR) ? 2'b10 : 2'b00;
   assign ahb.HBURST = 3'b000;
   assign ahb.HPROT  = 4'b0011;
   assign ahb.HWDATA = din_r;
   // bytes still owed after the current transfer: only split byte requests leave any
   always_comb begin
      nxt_mask = (ahb.HSIZE == 3'b000) ? (mask & ~(4'b0001 << ahb.HADDR[1:0])) : 4'b0000;
      last     = (nxt_mask == 4'b0000) || abort;
   end
   // request capture, address/data phase sequencing and completion pulses
   always_ff @(posedge HCLK) begin
      if (rst) begin
         state         <= S_IDLE;
         mask          <= 4'b0000;
         din_r         <= 32'h0;
         ahb_sram_done <= 1'b0;
         ahb_sram_err  <= 1'b0;
         ahb_sram_dout <= 32'h0;
         ahb.HADDR     <= 32'h0;
         ahb.HSIZE     <= 3'b000;
         ahb.HWRITE    <= 1'b0;
      end else begin
         ahb_sram_done <= 1'b0;
         ahb_sram_err  <= 1'b0;
         if (state == S_IDLE) begin
            if (sram_ahb_en) begin
               mask          <= m0;
               din_r         <= sram_ahb_din;
               ahb.HADDR     <= (BASE_ADDR & HI) | (addr_ext & 32'hffff_fffc) | {30'b0, lo_idx(m0)};
               ahb.HSIZE     <= sz_of(m0);
               ahb.HWRITE    <= sram_ahb_we;
               ahb_sram_done <= (m0 == 4'b0000);
               state         <= (m0 == 4'b0000) ? S_IDLE : S_ADDR;
            end
         end else if (state == S_ADDR) begin
            if (ahb.HREADY) state <= S_DATA;
         end else if (state == S_DATA) begin
            if (ahb.HREADY) begin
               if (!ahb.HWRITE) ahb_sram_dout <= ahb.HRDATA;
               state         <= last ? S_IDLE : S_ADDR;
               mask          <= last ? 4'b0000 : nxt_mask;
               ahb_sram_done <= last;
               ahb_sram_err  <= abort;
               if (!last) ahb.HADDR[1:0] <= lo_idx(nxt_mask);
            end
         end else begin
            state <= S_IDLE;
         end
      end
   end
endmodule

// File: tb/tb_ssram_to_ahb.sv
// tb_ssram_to_ahb: directed bench with transfer/completion scoreboard for ssram_to_ahb
module tb_ssram_to_ahb;
   typedef struct {logic [31:0] a; logic [2:0] s; logic w; logic [31:0] d;} xfer_t;
   typedef struct {logic rd; logic [31:0] dout; logic err;} done_t;
   logic HCLK = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0, we = 1'b0;
   logic [3:0] wb = 4'h0;
   logic [11:0] addr = 12'h0;
   logic [31:0] din = 32'h0;
   logic ready, done, err;
   logic [31:0] dout;
   logic hready = 1'b1, hresp = 1'b0;
   logic [31:0] hrdata = 32'h0;
   int total = 0, bad = 0;
   int n;
   xfer_t xq[$];
   done_t dq[$];
   xfer_t cur;
   logic dph = 1'b0;
   always #5 HCLK = ~HCLK;
   ssram_to_ahb_if bus();
   assign bus.HREADY = hready;
   assign bus.HRESP  = hresp;
   assign bus.HRDATA = hrdata;
   ssram_to_ahb #(.AW(12), .BASE_ADDR(32'h2000_0000)) dut (
      .HCLK(HCLK), .rst(rst), .sram_ahb_en(en), .sram_ahb_we(we), .sram_ahb_wb(wb),
      .sram_ahb_addr(addr), .sram_ahb_din(din), .ahb_sram_ready(ready), .ahb_sram_done(done),
      .ahb_sram_dout(dout), .ahb_sram_err(err), .ahb(bus.master));
   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask
   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask
   task automatic px(input logic [31:0] a, input logic [2:0] s, input logic w, input logic [31:0] d);
      xq.push_back('{a, s, w, d});
   endtask
   task automatic pd(input logic rd, input logic [31:0] o, input logic e);
      dq.push_back('{rd, o, e});
   endtask
   task automatic issue(input logic w, input logic [3:0] b, input logic [11:0] a, input logic [31:0] d);
      en = 1'b1; we = w; wb = b; addr = a; din = d;
      tick();
      en = 1'b0;
   endtask
   task automatic wait_done(input int n0, output int nn);
      nn = n0;
      while (!done && nn < 60) begin
         tick();
         nn++;
      end
      chk("done_seen", 32'(done), 32'd1);
   endtask
   // bus monitor: address phases and data phases checked against the expected transfer queue
   always @(negedge HCLK) begin
      if (rst) begin
         dph = 1'b0;
      end else begin
         if (dph && hready) begin
            if (cur.w) chk("hwdata", bus.HWDATA, cur.d);
            dph = 1'b0;
         end
         if (bus.HTRANS == 2'b10 && hready) begin
            total++;
            assert (xq.size() > 0) else begin
               bad++;
               $error("FAIL xfer_unexpected observed_haddr=%h expected=none", bus.HADDR);
            end
            if (xq.size() > 0) begin
               cur = xq.pop_front();
               chk("haddr", bus.HADDR, cur.a);
               chk("hsize", 32'(bus.HSIZE), 32'(cur.s));
               chk("hwrite", 32'(bus.HWRITE), 32'(cur.w));
               dph = 1'b1;
            end
         end
         if (done) begin
            total++;
            assert (dq.size() > 0) else begin
               bad++;
               $error("FAIL done_unexpected observed=1 expected=0");
            end
            if (dq.size() > 0) begin
               done_t e;
               e = dq.pop_front();
               chk("err", 32'(err), 32'(e.err));
               if (e.rd) chk("dout", dout, e.dout);
            end
         end
      end
   end
   initial begin
      tick();
      tick();
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_dout", dout, 32'h0);
      chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
      chk("rst_haddr", bus.HADDR, 32'h0);
      chk("rst_hsize", 32'(bus.HSIZE), 32'd0);
      chk("rst_hwrite", 32'(bus.HWRITE), 32'd0);
      chk("rst_hwdata", bus.HWDATA, 32'h0);
      chk("hburst", 32'(bus.HBURST), 32'd0);
      chk("hprot", 32'(bus.HPROT), 32'd3);
      rst = 1'b0;
      tick();
      hrdata = 32'hDEADBEEF;
      px(32'h2000_0124, 3'b010, 1'b0, 32'h0);
      pd(1'b1, 32'hDEADBEEF, 1'b0);
      issue(1'b0, 4'h0, 12'h124, 32'h0);
      chk("rd_htrans_t1", 32'(bus.HTRANS), 32'd2);
      chk("rd_busy_t1", 32'(ready), 32'd0);
      wait_done(1, n);
      chk("rd_latency", n, 3);
      chk("rd_ready_done", 32'(ready), 32'd1);
      px(32'h2000_0012, 3'b001, 1'b1, 32'hAABBCCDD);
      pd(1'b0, 32'h0, 1'b0);
      issue(1'b1, 4'hc, 12'h010, 32'hAABBCCDD);
      wait_done(1, n);
      chk("wr_half_latency", n, 3);
      px(32'h2000_0020, 3'b000, 1'b1, 32'h11223344);
      px(32'h2000_0022, 3'b000, 1'b1, 32'h11223344);
      pd(1'b0, 32'h0, 1'b0);
      issue(1'b1, 4'h5, 12'h020, 32'h11223344);
      wait_done(1, n);
      chk("wr_split2_latency", n, 5);
      px(32'h2000_0040, 3'b010, 1'b1, 32'h01020304);
      pd(1'b0, 32'h0, 1'b0);
      issue(1'b1, 4'hf, 12'h042, 32'h01020304);
      wait_done(1, n);
      px(32'h2000_0053, 3'b000, 1'b1, 32'h99887766);
      pd(1'b0, 32'h0, 1'b0);
      issue(1'b1, 4'h8, 12'h050, 32'h99887766);
      wait_done(1, n);
      px(32'h2000_0060, 3'b000, 1'b1, 32'h0badf00d);
      px(32'h2000_0062, 3'b000, 1'b1, 32'h0badf00d);
      px(32'h2000_0063, 3'b000, 1'b1, 32'h0badf00d);
      pd(1'b0, 32'h0, 1'b0);
      issue(1'b1, 4'hd, 12'h060, 32'h0badf00d);
      wait_done(1, n);
      chk("wr_split3_latency", n, 7);
      pd(1'b0, 32'h0, 1'b0);
      issue(1'b1, 4'h0, 12'h070, 32'h12345678);
      chk("wb0_htrans", 32'(bus.HTRANS), 32'd0);
      wait_done(1, n);
      chk("wb0_latency", n, 1);
      hrdata = 32'hCAFEF00D;
      px(32'h2000_0FFC, 3'b010, 1'b0, 32'h0);
      pd(1'b1, 32'hCAFEF00D, 1'b0);
      issue(1'b0, 4'h0, 12'hfff, 32'h0);
      hready = 1'b0;
      en = 1'b1; we = 1'b0; addr = 12'h100;
      for (int i = 0; i < 3; i++) begin
         chk("wait_haddr", bus.HADDR, 32'h2000_0FFC);
         chk("wait_htrans", 32'(bus.HTRANS), 32'd2);
         tick();
      end
      hready = 1'b1;
      chk("wait_haddr_last", bus.HADDR, 32'h2000_0FFC);
      tick();
      hready = 1'b0;
      tick();
      tick();
      hready = 1'b1;
      en = 1'b0;
      wait_done(7, n);
      chk("wait_latency", n, 8);
`ifdef SSRAM_TO_AHB_ERR_EN
      px(32'h2000_0030, 3'b000, 1'b1, 32'h55667788);
      pd(1'b0, 32'h0, 1'b1);
`else
      px(32'h2000_0030, 3'b000, 1'b1, 32'h55667788);
      px(32'h2000_0031, 3'b000, 1'b1, 32'h55667788);
      px(32'h2000_0033, 3'b000, 1'b1, 32'h55667788);
      pd(1'b0, 32'h0, 1'b0);
`endif
      issue(1'b1, 4'hb, 12'h030, 32'h55667788);
      tick();
      hready = 1'b0;
      hresp = 1'b1;
      chk("err_htrans_idle", 32'(bus.HTRANS), 32'd0);
      tick();
      hready = 1'b1;
      tick();
      hresp = 1'b0;
      wait_done(4, n);
`ifdef SSRAM_TO_AHB_ERR_EN
      chk("err_latency", n, 4);
`else
      chk("err_latency", n, 8);
`endif
      px(32'h2000_0080, 3'b000, 1'b1, 32'h76543210);
      issue(1'b1, 4'h5, 12'h080, 32'h76543210);
      tick();
      rst = 1'b1;
      tick();
      chk("mrst_ready", 32'(ready), 32'd1);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_htrans", 32'(bus.HTRANS), 32'd0);
      chk("mrst_haddr", bus.HADDR, 32'h0);
      chk("mrst_hwdata", bus.HWDATA, 32'h0);
      rst = 1'b0;
      tick();
      tick();
      chk("mrst_no_done", 32'(done), 32'd0);
      chk("mrst_no_xfer", 32'(bus.HTRANS), 32'd0);
      hrdata = 32'h0F0F1234;
      px(32'h2000_07FC, 3'b010, 1'b0, 32'h0);
      pd(1'b1, 32'h0F0F1234, 1'b0);
      issue(1'b0, 4'h3, 12'h7ff, 32'h0);
      wait_done(1, n);
      chk("post_rst_latency", n, 3);
      tick();
      chk("xq_empty", 32'(xq.size()), 32'd0);
      chk("dq_empty", 32'(dq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
